alu_host_sequencer: RTL and testbench
=====================================

Name: alu_host_sequencer

Overview:
- Command front-end for the shift/add ALU datapath and its one-hot control unit.
- Accepts one operation per valid/ready command handshake, pulses BEGIN, and drives INBUS with the correct operand whenever the control unit strobes a register load.
- Captures OUTBUS words on the control unit's push strobes, waits for END, and returns a formatted result through a valid/ready response handshake.
- Contains a watchdog that resets the ALU if END never arrives.

Parameters:
- WIDTH, 8: datapath / INBUS / OUTBUS width.
- TIMEOUT, 255: maximum cycles in RUN before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_a  in  WIDTH  add/sub: first operand; div: dividend high half.
- cmd_q  in  WIDTH  mul: multiplier; div: dividend low half.
- cmd_m  in  WIDTH  second operand / multiplicand / divisor.
- alu_reset  out  1  active-high reset to the control unit.
- alu_begin  out  1  BEGIN pulse.
- alu_op  out  2  op_code to the control unit, held stable for the whole operation.
- load_a, load_q, load_m  in  1 each  INBUS load strobes from the control unit.
- push_a, push_q  in  1 each  OUTBUS push strobes from the control unit.
- alu_end  in  1  END from the control unit.
- inbus  out  WIDTH  operand bus.
- outbus  in  WIDTH  result bus.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi  out  WIDTH  add/sub: result; mul: A (high product); div: remainder.
- rsp_lo  out  WIDTH  mul: Q (low product); div: quotient; add/sub: 0.
- rsp_err  out  1  timeout or protocol error for this operation.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE; all operand, op and result registers cleared.
  - cmd_ready=0 during reset, 1 from the first cycle after reset releases.
  - alu_reset=1 while reset=0.
  - alu_begin=0, rsp_valid=0, rsp_err=0, inbus=0, watchdog=0.
  - Reset mid-operation discards everything; no response is produced.
- States: IDLE, ISSUE, RUN, DONE, ABORT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/a/q/m, clear captures and error, go to ISSUE.
- ISSUE: alu_begin=1 for exactly one cycle, then go to RUN.
- alu_op is driven from the latched op in every state.
- inbus (RUN only, combinational, same cycle as the strobe):
  - load_a → a_reg; load_q → q_reg; load_m → m_reg; no strobe → 0.
  - Multiple simultaneous strobes → priority a>q>m and rsp_err set (sticky).
- Capture:
  - A push strobe at cycle t registers a flag; outbus is sampled at t+1 into the A or Q capture register.
  - For div, push_q precedes push_a; order is not checked, only the destination register.
- Completion:
  - alu_end in RUN marks end seen. END may coincide with the final capture cycle; both are honoured in that cycle.
  - Go to DONE when end has been seen and every expected capture is done (add/sub: A; mul: A,Q; div: A,Q).
  - END with a capture missing sets rsp_err and goes to DONE immediately.
- DONE:
  - rsp_valid=1 with stable rsp_hi, rsp_lo, rsp_err.
  - On rsp_ready, go to IDLE; cmd_ready rises the following cycle.
  - No back-to-back acceptance in the same cycle.
- Watchdog:
  - Counts cycles in RUN; cleared on entry to RUN.
  - Reaching TIMEOUT goes to ABORT.
- ABORT: alu_reset=1 for one cycle, rsp_err=1, then DONE with whatever was captured.
- Strobes outside RUN: ignored; rsp_err set if an operation is in flight.
- alu_end outside RUN: ignored.

Test Plan:
- Add, a=0x25, m=0x13, ALU model strobes load_a, load_m, push_a, END with outbus=0x38 → single alu_begin pulse; inbus 0x25 then 0x13 on strobe cycles; rsp_hi=0x38, rsp_lo=0, rsp_err=0.
- Mul, q=0x07, m=0x06, pushes A=0x00 then Q=0x2A → rsp_hi=0x00, rsp_lo=0x2A; response held over 3 cycles of rsp_ready=0 with stable values.
- Div, a=0x00, q=0x64, m=0x07, push_q (0x0E) then push_a (0x02), END coincident with the A capture cycle → rsp_lo=0x0E, rsp_hi=0x02, no error.
- Model never asserts END → after 255 RUN cycles alu_reset pulses for one cycle; rsp_valid=1, rsp_err=1.
- load_a and load_m asserted in the same cycle → inbus=a_reg and rsp_err=1 on the response.
- reset=0 asserted during RUN of a mul → next cycle IDLE, rsp_valid=0, alu_reset=1; a fresh add afterwards completes correctly.

Source files
------------

// File: rtl/alu_host_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_host_sequencer_if : command, ALU-control and response bundle | Rev 1.0
// ============================================================================
interface alu_host_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_q;
  logic [WIDTH-1:0] cmd_m;
  logic             alu_reset;
  logic             alu_begin;
  logic [1:0]       alu_op;
  logic             load_a;
  logic             load_q;
  logic             load_m;
  logic             push_a;
  logic             push_q;
  logic             alu_end;
  logic [WIDTH-1:0] inbus;
  logic [WIDTH-1:0] outbus;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_hi;
  logic [WIDTH-1:0] rsp_lo;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_q, cmd_m,
    input  load_a, load_q, load_m, push_a, push_q, alu_end, outbus, rsp_ready,
    output cmd_ready, alu_reset, alu_begin, alu_op, inbus,
    output rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_q, cmd_m,
    output load_a, load_q, load_m, push_a, push_q, alu_end, outbus, rsp_ready,
    input  cmd_ready, alu_reset, alu_begin, alu_op, inbus,
    input  rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_host_sequencer.sv
`default_nettype none
// ============================================================================
// alu_host_sequencer : command front-end and watchdog for the shift/add ALU
// Rev 1.0
// ============================================================================
module alu_host_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_host_sequencer_if.master bus
);
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa_q, opq_q, opm_q;
  logic [WIDTH-1:0] cap_a_q, cap_q_q;
  logic             got_a_q, got_q_q;
  logic             pend_a_q, pend_q_q;
  logic             end_seen_q;
  logic             err_q;
  logic [WD_W-1:0]  wd_q;

  logic w_run, w_accept, w_capture, w_in_flight, w_strobe, w_multi;
  logic w_end, w_have_a, w_have_q, w_caps_ok, w_timeout;

  assign w_run       = (state_q == S_RUN);
  assign w_accept    = bus.cmd_valid && bus.cmd_ready;
  assign w_capture   = w_run || (state_q == S_ABORT);
  assign w_in_flight = (state_q == S_ISSUE) || (state_q == S_ABORT);
  assign w_strobe    = bus.load_a | bus.load_q | bus.load_m | bus.push_a | bus.push_q;
  assign w_multi     = (bus.load_a & bus.load_q) | (bus.load_a & bus.load_m) |
                       (bus.load_q & bus.load_m);
  // A capture landing this cycle counts, so END may coincide with it
  assign w_end       = end_seen_q || bus.alu_end;
  assign w_have_a    = got_a_q || (pend_a_q && w_capture);
  assign w_have_q    = got_q_q || (pend_q_q && w_capture);
  assign w_caps_ok   = w_have_a && (w_have_q || !op_q[1]);
  assign w_timeout   = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RUN;
      S_RUN: begin
        if (w_end)          state_d = S_DONE;
        else if (w_timeout) state_d = S_ABORT;
      end
      S_ABORT: state_d = S_DONE;
      S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      opa_q      <= '0;
      opq_q      <= '0;
      opm_q      <= '0;
      cap_a_q    <= '0;
      cap_q_q    <= '0;
      got_a_q    <= 1'b0;
      got_q_q    <= 1'b0;
      pend_a_q   <= 1'b0;
      pend_q_q   <= 1'b0;
      end_seen_q <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q  <= state_d;
      pend_a_q <= w_run && bus.push_a;
      pend_q_q <= w_run && bus.push_q;

      if (w_accept) begin
        op_q       <= bus.cmd_op;
        opa_q      <= bus.cmd_a;
        opq_q      <= bus.cmd_q;
        opm_q      <= bus.cmd_m;
        cap_a_q    <= '0;
        cap_q_q    <= '0;
        got_a_q    <= 1'b0;
        got_q_q    <= 1'b0;
        end_seen_q <= 1'b0;
        err_q      <= 1'b0;
      end

      if (w_capture && pend_a_q) begin
        cap_a_q <= bus.outbus;
        got_a_q <= 1'b1;
      end
      if (w_capture && pend_q_q) begin
        cap_q_q <= bus.outbus;
        got_q_q <= 1'b1;
      end

      if (w_run) begin
        if (bus.alu_end)                 end_seen_q <= 1'b1;
        if (w_multi)                     err_q      <= 1'b1;
        if (w_end && !w_caps_ok)         err_q      <= 1'b1;
        if (!w_end && w_timeout)         err_q      <= 1'b1;
      end
      if (w_in_flight && w_strobe)       err_q      <= 1'b1;

      if (state_q == S_ISSUE)  wd_q <= '0;
      else if (w_run)          wd_q <= wd_q + 1'b1;
    end
  end

  always_comb begin
    bus.inbus = '0;
    if (w_run) begin
      if (bus.load_a)      bus.inbus = opa_q;
      else if (bus.load_q) bus.inbus = opq_q;
      else if (bus.load_m) bus.inbus = opm_q;
    end
  end

  assign bus.cmd_ready = reset && (state_q == S_IDLE);
  assign bus.alu_reset = !reset || (state_q == S_ABORT);
  assign bus.alu_begin = reset && (state_q == S_ISSUE);
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = reset && (state_q == S_DONE);
  assign bus.rsp_hi    = cap_a_q;
  assign bus.rsp_lo    = op_q[1] ? cap_q_q : '0;
  assign bus.rsp_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_host_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_host_sequencer : directed stimulus with queued expected responses
// Rev 1.0
// ============================================================================
module tb_alu_host_sequencer;
  localparam int W = 8;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LA   = 5'b10000;
  localparam logic [4:0] LQ   = 5'b01000;
  localparam logic [4:0] LM   = 5'b00100;
  localparam logic [4:0] PA   = 5'b00010;
  localparam logic [4:0] PQ   = 5'b00001;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_host_sequencer_if #(.WIDTH(W)) bus ();
  alu_host_sequencer #(.WIDTH(W), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rsp_t expq[$];
  int total = 0;
  int bad   = 0;

  function automatic rsp_t mk(input logic [7:0] hi, input logic [7:0] lo, input logic err);
    rsp_t r;
    r.hi = hi; r.lo = lo; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the oldest expectation on every accepted response
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        check("rsp_no_b2b_ready", {31'd0, bus.cmd_ready}, 32'd0);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got hi=0x%0h lo=0x%0h with none expected",
                   bus.rsp_hi, bus.rsp_lo);
        end else begin
          e = expq.pop_front();
          check("rsp_hi",  {24'd0, bus.rsp_hi}, {24'd0, e.hi});
          check("rsp_lo",  {24'd0, bus.rsp_lo}, {24'd0, e.lo});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q,
                      input logic [7:0] m, input rsp_t exp);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op;
    bus.cmd_a = a; bus.cmd_q = q; bus.cmd_m = m;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    expq.push_back(exp);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("begin_pulse", {31'd0, bus.alu_begin}, 32'd1);
    check("alu_op", {30'd0, bus.alu_op}, {30'd0, op});
    @(negedge clk);
    check("begin_drop", {31'd0, bus.alu_begin}, 32'd0);
  endtask

  // One control-unit cycle: strobes {la,lq,lm,pa,pq}, END and OUTBUS
  task automatic cu(input logic [4:0] s, input logic en, input logic [7:0] ob,
                    input logic [7:0] exp_in);
    @(posedge clk); #1;
    {bus.load_a, bus.load_q, bus.load_m, bus.push_a, bus.push_q} = s;
    bus.alu_end = en;
    bus.outbus  = ob;
    @(negedge clk);
    check("inbus", {24'd0, bus.inbus}, {24'd0, exp_in});
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin
      @(negedge clk); #2;
      n++;
    end
    check("rsp_arrived", expq.size(), 32'd0);
    @(negedge clk);
    check("cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] m, input logic [7:0] r);
    send(2'b00, a, 8'h00, m, mk(r, 8'h00, 1'b0));
    cu(LA, 1'b0, 8'h00, a);
    cu(LM, 1'b0, 8'h00, m);
    cu(PA, 1'b0, r, 8'h00);
    cu(NONE, 1'b1, r, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    wait_rsp();
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    bus.cmd_a = '0; bus.cmd_q = '0; bus.cmd_m = '0;
    {bus.load_a, bus.load_q, bus.load_m, bus.push_a, bus.push_q} = NONE;
    bus.alu_end = 1'b0; bus.outbus = '0; bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    check("rst_inbus",     {24'd0, bus.inbus},     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rel_alu_reset", {31'd0, bus.alu_reset}, 32'd0);

    // add and sub
    run_add(8'h25, 8'h13, 8'h38);
    send(2'b01, 8'h50, 8'h00, 8'h10, mk(8'h40, 8'h00, 1'b0));
    cu(LA, 1'b0, 8'h00, 8'h50);
    cu(LM, 1'b0, 8'h00, 8'h10);
    cu(PA, 1'b0, 8'h40, 8'h00);
    cu(NONE, 1'b1, 8'h40, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    wait_rsp();

    // mul with response held under back-pressure
    bus.rsp_ready = 1'b0;
    send(2'b10, 8'h00, 8'h07, 8'h06, mk(8'h00, 8'h2A, 1'b0));
    cu(LQ, 1'b0, 8'h00, 8'h07);
    cu(LM, 1'b0, 8'h00, 8'h06);
    cu(PA, 1'b0, 8'h00, 8'h00);
    cu(PQ, 1'b0, 8'h00, 8'h00);
    cu(NONE, 1'b1, 8'h2A, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_hi", {24'd0, bus.rsp_hi}, 32'h00);
      check("hold_lo", {24'd0, bus.rsp_lo}, 32'h2A);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_rsp();

    // div: push_q then push_a, END coincident with the A capture
    send(2'b11, 8'h00, 8'h64, 8'h07, mk(8'h02, 8'h0E, 1'b0));
    cu(LA, 1'b0, 8'h00, 8'h00);
    cu(LQ, 1'b0, 8'h00, 8'h64);
    cu(LM, 1'b0, 8'h00, 8'h07);
    cu(PQ, 1'b0, 8'h0E, 8'h00);
    cu(PA, 1'b0, 8'h0E, 8'h00);
    cu(NONE, 1'b1, 8'h02, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    wait_rsp();

    // simultaneous loads: priority to A, sticky error
    send(2'b00, 8'h11, 8'h00, 8'h22, mk(8'h33, 8'h00, 1'b1));
    cu(LA | LM, 1'b0, 8'h00, 8'h11);
    cu(LM, 1'b0, 8'h00, 8'h22);
    cu(PA, 1'b0, 8'h33, 8'h00);
    cu(NONE, 1'b1, 8'h33, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    wait_rsp();

    // END with no capture: error, straight to DONE
    send(2'b00, 8'h01, 8'h00, 8'h02, mk(8'h00, 8'h00, 1'b1));
    cu(LA, 1'b0, 8'h00, 8'h01);
    cu(NONE, 1'b1, 8'h00, 8'h00);
    cu(NONE, 1'b0, 8'h00, 8'h00);
    wait_rsp();

    // watchdog: END never arrives
    send(2'b00, 8'hAA, 8'h00, 8'hBB, mk(8'h00, 8'h00, 1'b1));
    n = 1;
    while (bus.alu_reset !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", n, 32'd256);
    @(negedge clk);
    check("wd_reset_pulse", {31'd0, bus.alu_reset}, 32'd0);
    check("wd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    wait_rsp();

    // reset during a mul discards it
    send(2'b10, 8'h00, 8'h07, 8'h06, mk(8'h00, 8'h2A, 1'b0));
    cu(LQ, 1'b0, 8'h00, 8'h07);
    @(posedge clk); #1;
    reset = 1'b0;
    {bus.load_a, bus.load_q, bus.load_m, bus.push_a, bus.push_q} = NONE;
    expq.delete();
    @(negedge clk);
    check("mid_rst_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
    check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("post_rst_alu_op",    {30'd0, bus.alu_op},    32'd0);
    run_add(8'h25, 8'h13, 8'h38);

    repeat (3) @(negedge clk);
    check("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
